// File: rtl/wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// wb_rr_arbiter
//   Round-robin arbiter that shares one Wishbone slave port among NMASTERS
//   masters. The grant is registered. The granted master's request fields are
//   muxed to the slave. Slave responses return only to that master. A
//   per-transfer watchdog answers ERR to the owner when the slave never
//   terminates a strobed transfer.
//
// Parameters
//   NMASTERS  number of requesting masters (2..8)
//   TIMEOUT   strobed cycles without ACK/ERR/RTY before the watchdog answers ERR
//   TOW       watchdog counter width (2**TOW >= TIMEOUT+1)
//
// Ports
//   p_clk, p_resetn                       clock / async active-low reset
//   m_CYC_I, m_STB_I, m_WE_I, m_LOCK_I    per-master controls (one bit each)
//   m_SEL_I [4*N], m_ADR_I/m_DAT_I [32*N] per-master request fields
//   m_DAT_O                               slave read data, broadcast
//   m_ACK_O, m_ERR_O, m_RTY_O             per-master responses (owner only)
//   s_CYC_O, s_STB_O, s_WE_O, s_LOCK_O    slave-side controls
//   s_SEL_O, s_ADR_O, s_DAT_O             slave-side request fields
//   s_DAT_I, s_ACK_I, s_ERR_I, s_RTY_I    slave responses
//   grant_o                               one-hot grant, 0 when idle
//   busy_o                                |grant_o
// ---------------------------------------------------------------------------
module wb_rr_arbiter #(
  parameter int NMASTERS = 2,
  parameter int TIMEOUT  = 16,
  parameter int TOW      = 5
) (
  input  logic                     p_clk,
  input  logic                     p_resetn,
  input  logic [NMASTERS-1:0]      m_CYC_I,
  input  logic [NMASTERS-1:0]      m_STB_I,
  input  logic [NMASTERS-1:0]      m_WE_I,
  input  logic [NMASTERS-1:0]      m_LOCK_I,
  input  logic [4*NMASTERS-1:0]    m_SEL_I,
  input  logic [32*NMASTERS-1:0]   m_ADR_I,
  input  logic [32*NMASTERS-1:0]   m_DAT_I,
  output logic [31:0]              m_DAT_O,
  output logic [NMASTERS-1:0]      m_ACK_O,
  output logic [NMASTERS-1:0]      m_ERR_O,
  output logic [NMASTERS-1:0]      m_RTY_O,
  output logic                     s_CYC_O,
  output logic                     s_STB_O,
  output logic                     s_WE_O,
  output logic                     s_LOCK_O,
  output logic [3:0]               s_SEL_O,
  output logic [31:0]              s_ADR_O,
  output logic [31:0]              s_DAT_O,
  input  logic [31:0]              s_DAT_I,
  input  logic                     s_ACK_I,
  input  logic                     s_ERR_I,
  input  logic                     s_RTY_I,
  output logic [NMASTERS-1:0]      grant_o,
  output logic                     busy_o
);

  localparam int IW = (NMASTERS > 1) ? $clog2(NMASTERS) : 1;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_OWNED = 1'b1;

  localparam logic [NMASTERS-1:0] ONE      = NMASTERS'(1);
  localparam logic [TOW-1:0]      WD_LIMIT = TOW'(TIMEOUT);

  logic          state_q, state_d;
  logic [IW-1:0] g_q, g_d;       // index of the current owner
  logic [IW-1:0] ptr_q, ptr_d;   // round-robin search start
  logic [TOW-1:0] wd_q, wd_d;

  logic                owned;
  logic                release_g;
  logic                strobing;
  logic                wd_hit;
  logic                slv_resp;
  logic [NMASTERS-1:0] req;
  logic [NMASTERS-1:0] g_onehot;
  int                  start;
  logic                found;
  logic [IW-1:0]       win;

  assign owned    = (state_q == ST_OWNED);
  assign g_onehot = owned ? (ONE << g_q) : '0;

  // Owner gives the bus back only when it has neither CYC nor LOCK; LOCK
  // alone keeps the grant across gaps between cycles.
  assign release_g = owned && !m_CYC_I[g_q] && !m_LOCK_I[g_q];

  // Arbitration. While idle the search starts at ptr. On release the search
  // starts just after the old owner and excludes it, so the next owner takes
  // over on the same edge without a dead cycle.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    start = int'(ptr_q);
    req   = m_CYC_I;
    found = 1'b0;
    win   = '0;
    if (release_g) begin
      start = (int'(g_q) + 1) % NMASTERS;
      req   = m_CYC_I & ~(ONE << g_q);
    end
    for (int k = 0; k < NMASTERS; k++) begin
      int idx;
      idx = (start + k) % NMASTERS;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ptr_d   = ptr_q;
    if (!owned) begin
      if (found) begin
        state_d = ST_OWNED;
        g_d     = win;
      end
    end else if (release_g) begin
      ptr_d = IW'(start);
      if (found) begin
        state_d = ST_OWNED;
        g_d     = win;
      end else begin
        state_d = ST_IDLE;
      end
    end
  end

  // Watchdog: counts strobed cycles that get no termination. When it reaches
  // TIMEOUT the arbiter answers ERR itself for one cycle and withholds STB
  // from the slave, then the count restarts.
  assign strobing = owned && m_CYC_I[g_q] && m_STB_I[g_q];
  assign slv_resp = s_ACK_I | s_ERR_I | s_RTY_I;
  assign wd_hit   = strobing && (wd_q == WD_LIMIT);

  always_comb begin
    wd_d = wd_q + TOW'(1);
    if (release_g || !strobing || slv_resp || wd_hit) begin
      wd_d = '0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge p_clk or negedge p_resetn) begin
    if (!p_resetn) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
    end
  end

  // Request mux: everything is zero while no master owns the bus, so an
  // asserted reset drops the slave side immediately.
  always_comb begin
    s_CYC_O  = 1'b0;
    s_WE_O   = 1'b0;
    s_LOCK_O = 1'b0;
    s_SEL_O  = '0;
    s_ADR_O  = '0;
    s_DAT_O  = '0;
    if (owned) begin
      s_CYC_O  = m_CYC_I[g_q];
      s_WE_O   = m_WE_I[g_q];
      s_LOCK_O = m_LOCK_I[g_q];
      s_SEL_O  = m_SEL_I[4*int'(g_q) +: 4];
      s_ADR_O  = m_ADR_I[32*int'(g_q) +: 32];
      s_DAT_O  = m_DAT_I[32*int'(g_q) +: 32];
    end
  end

  assign s_STB_O = strobing && !wd_hit;

  // Responses reach the owner only; a slave ACK outranks a watchdog ERR.
  assign m_DAT_O = s_DAT_I;
  assign m_ACK_O = s_ACK_I ? g_onehot : '0;
  assign m_RTY_O = s_RTY_I ? g_onehot : '0;
  assign m_ERR_O = (s_ERR_I || (wd_hit && !s_ACK_I)) ? g_onehot : '0;

  assign grant_o = g_onehot;
  assign busy_o  = owned;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_rr_arbiter
//   Directed bench for wb_rr_arbiter with three masters and TIMEOUT=16.
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   after they settle, away from the edge. The slave either acknowledges
//   every strobe combinationally (ack_en) or stays silent; ack_force injects
//   a single ACK.
// ---------------------------------------------------------------------------
module tb_wb_rr_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;

  logic            p_clk = 1'b0;
  logic            p_resetn = 1'b0;
  logic [N-1:0]    cyc, stb, we, lock;
  logic [4*N-1:0]  sel;
  logic [32*N-1:0] adr, dat;
  logic [31:0]     m_dat_o;
  logic [N-1:0]    m_ack, m_err, m_rty;
  logic            s_cyc, s_stb, s_we, s_lock;
  logic [3:0]      s_sel;
  logic [31:0]     s_adr, s_dat_o;
  logic [31:0]     s_dat_i;
  logic            s_ack, s_err, s_rty;
  logic [N-1:0]    grant;
  logic            busy;
  logic            ack_en, ack_force;

  int tests_run = 0;
  int tests_failed = 0;

  assign s_ack = ack_force | (ack_en & s_cyc & s_stb);
  assign s_err = 1'b0;
  assign s_rty = 1'b0;

  always #5 p_clk = ~p_clk;

  wb_rr_arbiter #(.NMASTERS(N), .TIMEOUT(TO), .TOW(5)) dut (
    .p_clk    (p_clk),
    .p_resetn (p_resetn),
    .m_CYC_I  (cyc),
    .m_STB_I  (stb),
    .m_WE_I   (we),
    .m_LOCK_I (lock),
    .m_SEL_I  (sel),
    .m_ADR_I  (adr),
    .m_DAT_I  (dat),
    .m_DAT_O  (m_dat_o),
    .m_ACK_O  (m_ack),
    .m_ERR_O  (m_err),
    .m_RTY_O  (m_rty),
    .s_CYC_O  (s_cyc),
    .s_STB_O  (s_stb),
    .s_WE_O   (s_we),
    .s_LOCK_O (s_lock),
    .s_SEL_O  (s_sel),
    .s_ADR_O  (s_adr),
    .s_DAT_O  (s_dat_o),
    .s_DAT_I  (s_dat_i),
    .s_ACK_I  (s_ack),
    .s_ERR_I  (s_err),
    .s_RTY_I  (s_rty),
    .grant_o  (grant),
    .busy_o   (busy)
  );

  task automatic check(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to 1 time unit past the next rising edge.
  task automatic step();
    @(posedge p_clk);
    #1;
  endtask

  task automatic do_reset();
    p_resetn  = 1'b0;
    cyc = '0; stb = '0; we = '0; lock = '0;
    ack_en = 1'b0; ack_force = 1'b0;
    repeat (2) @(posedge p_clk);
    @(negedge p_clk);
    p_resetn = 1'b1;
    #1;
  endtask

  // Per-master request fields, fixed for the whole run.
  initial begin
    sel     = {4'hC, 4'h3, 4'hF};
    adr     = {32'h0000_0300, 32'h0000_0200, 32'h0000_0010};
    dat     = {32'h3333_0003, 32'h2222_0002, 32'hCAFE_0001};
    s_dat_i = 32'h1234_5678;
  end

  initial begin : main
    int errs, first_err, second_err, m1_err, stb_bad, nseq;
    logic [N-1:0] acked, last;
    logic [N-1:0] seq [6];
    logic [N-1:0] exp_seq [6];

    // ---------------- reset state ----------------
    do_reset();
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_busy",  64'(busy),  64'h0);
    check("rst_s_cyc", 64'(s_cyc), 64'h0);
    check("rst_s_stb", 64'(s_stb), 64'h0);
    check("rst_resp",  64'({m_ack, m_err, m_rty}), 64'h0);

    // ---------------- 1: m0 single write ----------------
    ack_en = 1'b1;
    cyc = 3'b001; stb = 3'b001; we = 3'b001;
    #1;
    check("t1_no_grant_before_edge", 64'(grant), 64'h0);
    step();
    check("t1_grant",  64'(grant),   64'b001);
    check("t1_busy",   64'(busy),    64'h1);
    check("t1_s_adr",  64'(s_adr),   64'h10);
    check("t1_s_dat",  64'(s_dat_o), 64'hCAFE_0001);
    check("t1_s_we",   64'(s_we),    64'h1);
    check("t1_s_sel",  64'(s_sel),   64'hF);
    check("t1_ack",    64'(m_ack),   64'b001);
    check("t1_rdata",  64'(m_dat_o), 64'h1234_5678);
    cyc = '0; stb = '0; we = '0;
    step();
    check("t1_idle", 64'(grant), 64'h0);

    // ---------------- 2: simultaneous m0/m1, handover ----------------
    do_reset();
    ack_en = 1'b1;
    cyc = 3'b011; stb = 3'b011;
    step();
    check("t2_grant_m0", 64'(grant), 64'b001);
    check("t2_ack_m0",   64'(m_ack), 64'b001);
    check("t2_adr_m0",   64'(s_adr), 64'h10);
    cyc = 3'b010; stb = 3'b010;
    step();
    check("t2_grant_m1", 64'(grant), 64'b010);
    check("t2_ack_m1",   64'(m_ack), 64'b010);
    check("t2_adr_m1",   64'(s_adr), 64'h200);

    // ---------------- 3: m1 LOCK holds grant across CYC gap ----------------
    cyc = 3'b001; stb = 3'b001; lock = 3'b010;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t3_lock_grant_%0d", i), 64'(grant), 64'b010);
      check($sformatf("t3_lock_s_cyc_%0d", i), 64'(s_cyc), 64'h0);
      check($sformatf("t3_lock_s_lock_%0d", i), 64'(s_lock), 64'h1);
      check($sformatf("t3_lock_no_ack_%0d", i), 64'(m_ack), 64'h0);
    end
    lock = '0;
    step();
    check("t3_grant_m0", 64'(grant), 64'b001);
    check("t3_ack_m0",   64'(m_ack), 64'b001);
    cyc = '0; stb = '0;
    step();
    check("t3_idle", 64'(grant), 64'h0);

    // ---------------- 5: async reset mid-transfer (ptr is 1 here) ----------------
    ack_en = 1'b0;
    cyc = 3'b010; stb = 3'b010;
    step();
    check("t5_grant_m1", 64'(grant), 64'b010);
    #2;
    p_resetn = 1'b0;
    #1;
    check("t5_rst_grant", 64'(grant), 64'h0);
    check("t5_rst_s_cyc", 64'(s_cyc), 64'h0);
    check("t5_rst_s_stb", 64'(s_stb), 64'h0);
    cyc = 3'b011; stb = 3'b011;
    @(negedge p_clk);
    p_resetn = 1'b1;
    step();
    check("t5_ptr0_grant_m0", 64'(grant), 64'b001);

    // ---------------- 4: watchdog, silent slave ----------------
    do_reset();
    ack_en = 1'b0;
    cyc = 3'b011; stb = 3'b011;
    step();
    errs = 0; first_err = 0; second_err = 0; m1_err = 0; stb_bad = 0;
    for (int k = 1; k <= 51; k++) begin
      ack_force = (k == 51);
      #1;
      if (m_err[0]) begin
        errs++;
        if (errs == 1) first_err = k;
        if (errs == 2) second_err = k;
      end
      if (m_err[1]) m1_err++;
      if (k != 51 && s_stb == m_err[0]) stb_bad++;
      if (k == 51) begin
        check("t4_ack_wins_ack", 64'(m_ack), 64'b001);
        check("t4_ack_wins_err", 64'(m_err), 64'h0);
      end
      @(posedge p_clk);
    end
    #1;
    ack_force = 1'b0;
    check("t4_err_count",   64'(errs),       64'd2);
    check("t4_first_err",   64'(first_err),  64'(TO + 1));
    check("t4_second_err",  64'(second_err), 64'(2 * (TO + 1)));
    check("t4_m1_never_err", 64'(m1_err),    64'd0);
    check("t4_stb_withheld", 64'(stb_bad),   64'd0);
    check("t4_grant_kept",  64'(grant),      64'b001);

    // ---------------- 6: fair rotation among all masters ----------------
    do_reset();
    ack_en = 1'b1;
    cyc = 3'b111; stb = 3'b111;
    acked = '0; last = '0; nseq = 0;
    exp_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    for (int c = 0; c < 60 && nseq < 6; c++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (!grant[i]) acked[i] = 1'b0;
        cyc[i] = !(grant[i] && acked[i]);
      end
      stb = cyc;
      #1;
      if (grant != '0 && grant != last) begin
        seq[nseq] = grant;
        nseq++;
      end
      last = grant;
      for (int i = 0; i < N; i++) if (m_ack[i]) acked[i] = 1'b1;
    end
    check("t6_grant_changes", 64'(nseq), 64'd6);
    for (int i = 0; i < 6; i++) begin
      if (i < nseq) check($sformatf("t6_seq_%0d", i), 64'(seq[i]), 64'(exp_seq[i]));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Global time bound so the run always terminates.
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, got %0d checks, expected completion", tests_run);
    $fatal(1);
  end

endmodule
